// File: rtl/dmem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl_if
// Description : Bundle of the pipeline request/response handshake and the
//               block-RAM data-memory port around dmem_access_ctrl.
//
//               master : controller view (drives req_ready, resp_*, stall and
//                        the mem_* strobes, address and write data).
//               slave  : environment view (MEM stage plus data memory; drives
//                        req_* and mem_read_data).
//
//               Request side  : req_valid, req_ready, req_write, req_addr,
//                               req_wdata, req_sign_mask
//               Response side : resp_valid, resp_rdata, resp_err, stall
//               Memory side   : mem_addr, mem_write_data, mem_memwrite,
//                               mem_memread, mem_read_data
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_access_ctrl_if;

    // Pipeline request
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_sign_mask;

    // Pipeline response
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    // Data-memory port
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_read_data;

    modport master (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  req_sign_mask,
        input  mem_read_data,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err,
        output stall,
        output mem_addr,
        output mem_write_data,
        output mem_memwrite,
        output mem_memread
    );

    modport slave (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        output req_sign_mask,
        output mem_read_data,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err,
        input  stall,
        input  mem_addr,
        input  mem_write_data,
        input  mem_memwrite,
        input  mem_memread
    );

endinterface
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl
// Description : Processor-side initiator for data-memory loads and stores.
//               Takes one request at a time from the MEM stage, issues
//               word-aligned read/write strobes to a block RAM that only
//               writes whole 32-bit words, extracts and extends load data,
//               and performs read-modify-write for byte/halfword stores.
//               The pipeline is stalled until the access completes.
//
// Parameters  : READ_LATENCY - cycles from a mem_memread cycle until
//                              mem_read_data is valid (1..4)
//               MEM_WORDS    - number of 32-bit words in data memory
//               LED_ADDR     - memory-mapped LED word address, always legal
//
// Ports       : clk      - system clock, rising edge
//               reset_n  - synchronous active-low reset
//               bus      - dmem_access_ctrl_if.master (request, response,
//                          stall and data-memory signals)
//
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int          READ_LATENCY = 1,
    parameter int          MEM_WORDS    = 1024,
    parameter logic [31:0] LED_ADDR     = 32'h0000_2000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    dmem_access_ctrl_if.master     bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Wait counter is loaded in READ; WAIT exits once it reaches zero, so the
    // exit cycle lands exactly READ_LATENCY cycles after the read strobe.
    localparam logic [1:0]  c_wait_load = 2'(READ_LATENCY - 1);
    localparam logic [31:0] c_mem_words = 32'(MEM_WORDS);

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Latched request
    logic [31:0] r_addr;
    logic [15:0] r_wdata;       // only the sub-word part is needed after accept
    logic [1:0]  r_size;        // sign_mask[2:1]
    logic        r_sext;        // sign_mask[3]
    logic        r_write;
    logic [1:0]  r_cnt;

    logic [31:0] w_addr_next;
    logic [15:0] w_wdata_next;
    logic [1:0]  w_size_next;
    logic        w_sext_next;
    logic        w_write_next;
    logic [1:0]  w_cnt_next;

    // Registered outputs
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_mem_memread;
    logic        r_mem_memwrite;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_write_data;

    logic        w_resp_valid_next;
    logic [31:0] w_resp_rdata_next;
    logic        w_resp_err_next;
    logic        w_mem_memread_next;
    logic        w_mem_memwrite_next;
    logic [31:0] w_mem_addr_next;
    logic [31:0] w_mem_write_data_next;

    // ------------------------------------------------------------------------
    // Request decode (only meaningful in IDLE, where the request is accepted)
    // ------------------------------------------------------------------------
    logic        w_req_is_word;
    logic        w_req_is_half;
    logic        w_req_misalign;
    logic        w_req_range_err;
    logic        w_req_err;
    logic [31:0] w_req_word_idx;
    logic        w_unused;

    assign w_req_is_word   = bus.req_sign_mask[2];
    assign w_req_is_half   = ~bus.req_sign_mask[2] & bus.req_sign_mask[1];
    assign w_req_word_idx  = {2'b00, bus.req_addr[31:2]};
    assign w_req_misalign  = (w_req_is_half & bus.req_addr[0]) |
                             (w_req_is_word & (bus.req_addr[1:0] != 2'b00));
    // The LED register sits outside the RAM range but must stay reachable.
    assign w_req_range_err = (w_req_word_idx >= c_mem_words) &&
                             (bus.req_addr != LED_ADDR);
    assign w_req_err       = w_req_misalign | w_req_range_err;

    // sign_mask[0] carries no meaning for this controller.
    assign w_unused        = bus.req_sign_mask[0];

    // ------------------------------------------------------------------------
    // Load extraction: pick the lane addressed by the low address bits and
    // sign- or zero-extend it. Word loads pass through untouched.
    // ------------------------------------------------------------------------
    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        sext
    );
        logic [15:0] half;
        logic [7:0]  byte_v;
        logic [31:0] result;
        half = lane[1] ? word[31:16] : word[15:0];
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        if (size[1]) begin
            result = word;
        end else if (size[0]) begin
            result = {{16{sext & half[15]}}, half};
        end else begin
            result = {{24{sext & byte_v[7]}}, byte_v};
        end
        return result;
    endfunction

    // ------------------------------------------------------------------------
    // Store merge: overwrite only the addressed lane of the word just read,
    // so the full-word write leaves neighbouring bytes intact.
    // ------------------------------------------------------------------------
    function automatic logic [31:0] merge_store(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic        is_half,
        input logic [15:0] data
    );
        logic [31:0] result;
        result = word;
        if (is_half) begin
            if (lane[1]) result[31:16] = data;
            else         result[15:0]  = data;
        end else begin
            case (lane)
                2'd0:    result[7:0]   = data[7:0];
                2'd1:    result[15:8]  = data[7:0];
                2'd2:    result[23:16] = data[7:0];
                default: result[31:24] = data[7:0];
            endcase
        end
        return result;
    endfunction

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. Every output register is loaded with
    // the value that belongs to the state being entered, so strobes and
    // resp_valid line up exactly with the state that owns them.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next          = r_state;
        w_addr_next           = r_addr;
        w_wdata_next          = r_wdata;
        w_size_next           = r_size;
        w_sext_next           = r_sext;
        w_write_next          = r_write;
        w_cnt_next            = r_cnt;
        w_resp_valid_next     = 1'b0;
        w_resp_rdata_next     = 32'h0;
        w_resp_err_next       = 1'b0;
        w_mem_memread_next    = 1'b0;
        w_mem_memwrite_next   = 1'b0;
        w_mem_addr_next       = 32'h0;
        w_mem_write_data_next = r_mem_write_data;

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_addr_next  = bus.req_addr;
                    w_wdata_next = bus.req_wdata[15:0];
                    w_size_next  = bus.req_sign_mask[2:1];
                    w_sext_next  = bus.req_sign_mask[3];
                    w_write_next = bus.req_write;
                    if (w_req_err) begin
                        w_state_next      = S_RESP;
                        w_resp_valid_next = 1'b1;
                        w_resp_err_next   = 1'b1;
                    end else if (bus.req_write && w_req_is_word) begin
                        // Full-word store needs no read: write straight away.
                        w_state_next          = S_WRITE;
                        w_mem_memwrite_next   = 1'b1;
                        w_mem_addr_next       = {bus.req_addr[31:2], 2'b00};
                        w_mem_write_data_next = bus.req_wdata;
                    end else begin
                        w_state_next       = S_READ;
                        w_mem_memread_next = 1'b1;
                        w_mem_addr_next    = {bus.req_addr[31:2], 2'b00};
                    end
                end
            end

            S_READ: begin
                w_state_next    = S_WAIT;
                w_cnt_next      = c_wait_load;
                w_mem_addr_next = {r_addr[31:2], 2'b00};
            end

            S_WAIT: begin
                if (r_cnt == 2'd0) begin
                    if (r_write) begin
                        w_state_next          = S_WRITE;
                        w_mem_memwrite_next   = 1'b1;
                        w_mem_addr_next       = {r_addr[31:2], 2'b00};
                        w_mem_write_data_next = merge_store(bus.mem_read_data,
                                                            r_addr[1:0],
                                                            r_size[0],
                                                            r_wdata);
                    end else begin
                        w_state_next      = S_RESP;
                        w_resp_valid_next = 1'b1;
                        w_resp_rdata_next = extract_load(bus.mem_read_data,
                                                         r_addr[1:0],
                                                         r_size,
                                                         r_sext);
                    end
                end else begin
                    w_cnt_next      = r_cnt - 2'd1;
                    w_mem_addr_next = {r_addr[31:2], 2'b00};
                end
            end

            S_WRITE: begin
                w_state_next      = S_RESP;
                w_resp_valid_next = 1'b1;
            end

            S_RESP: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers. Reset aborts any access in flight: with all
    // strobes and resp_valid cleared, nothing further reaches memory or the
    // pipeline.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_addr           <= 32'h0;
            r_wdata          <= 16'h0;
            r_size           <= 2'b00;
            r_sext           <= 1'b0;
            r_write          <= 1'b0;
            r_cnt            <= 2'd0;
            r_resp_valid     <= 1'b0;
            r_resp_rdata     <= 32'h0;
            r_resp_err       <= 1'b0;
            r_mem_memread    <= 1'b0;
            r_mem_memwrite   <= 1'b0;
            r_mem_addr       <= 32'h0;
            r_mem_write_data <= 32'h0;
        end else begin
            r_state          <= w_state_next;
            r_addr           <= w_addr_next;
            r_wdata          <= w_wdata_next;
            r_size           <= w_size_next;
            r_sext           <= w_sext_next;
            r_write          <= w_write_next;
            r_cnt            <= w_cnt_next;
            r_resp_valid     <= w_resp_valid_next;
            r_resp_rdata     <= w_resp_rdata_next;
            r_resp_err       <= w_resp_err_next;
            r_mem_memread    <= w_mem_memread_next;
            r_mem_memwrite   <= w_mem_memwrite_next;
            r_mem_addr       <= w_mem_addr_next;
            r_mem_write_data <= w_mem_write_data_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // stall is combinational so the request cycle itself is frozen; RESP
    // releases the pipeline one cycle before the controller is ready again.
    assign bus.req_ready      = (r_state == S_IDLE);
    assign bus.stall          = ((r_state == S_IDLE) && bus.req_valid) ||
                                ((r_state != S_IDLE) && (r_state != S_RESP));
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_rdata     = r_resp_rdata;
    assign bus.resp_err       = r_resp_err;
    assign bus.mem_memread    = r_mem_memread;
    assign bus.mem_memwrite   = r_mem_memwrite;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_write_data = r_mem_write_data;

endmodule
`default_nettype wire
